// File: rtl/dip_scan_pkg.sv
// Shared types and helpers for the DIP switch scan reader.
// Holds the scan FSM state encoding and the counter width helper used
// by the reader top level and its tick divider.
package dip_scan_pkg;

    // Scan sequence: idle, parallel load, then low/high half of each
    // serial clock, then one cycle to publish the frame.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        UPDATE   = 3'd4
    } scan_state_t;

    // Width of a counter that must hold 0..n-1; never less than one bit
    // so degenerate sizes still give a legal vector.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dip_scan_reader_if.sv
// Serial link to the 74HC165-style shift register chain.
// The reader (master) drives the shift clock and the active-low load
// strobe and receives serial data from the last register in the chain.
interface dip_scan_reader_if;

    logic dip_sin;
    logic dip_sclk;
    logic dip_latch_n;

    modport master (
        input  dip_sin,
        output dip_sclk,
        output dip_latch_n
    );

    modport slave (
        output dip_sin,
        input  dip_sclk,
        input  dip_latch_n
    );

endinterface

// File: rtl/dip_tick_gen.sv
// Scan tick divider: counts 0..CLK_DIV-1 and pulses tick for one clk
// at the terminal count. While clr is high the count is held at zero
// and no tick is produced, so every phase started after a clear lasts
// exactly CLK_DIV clocks.
module dip_tick_gen
    import dip_scan_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int            DW       = cnt_width(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] count;

    // Free-running modulo-CLK_DIV count, parked at zero while cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || (count == DIV_LAST)) begin
            count <= '0;
        end else begin
            count <= count + DW'(1);
        end
    end

    assign tick = !clr && (count == DIV_LAST);

endmodule

// File: rtl/dip_scan_reader.sv
// Serial reader for the DIP switch shift register chain.
// Generates a divided shift clock and an active-low load strobe, shifts
// in N_BITS per frame and publishes the word on data_out with one-clk
// data_valid / data_changed strobes, scanning continuously while
// scan_en is high.
// Optional build macro DIP_DEBOUNCE_EN: data_out only follows a word
// after DEB_FRAMES identical consecutive frames (first frame excepted).
module dip_scan_reader
    import dip_scan_pkg::*;
#(
    parameter int N_BITS     = 24,
    parameter int CLK_DIV    = 4,
    parameter int MSB_FIRST  = 1,
    parameter int DEB_FRAMES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scan_en,
    dip_scan_reader_if.master   chain,
    output logic [N_BITS-1:0]   data_out,
    output logic                data_valid,
    output logic                data_changed,
    output logic                busy
);

    localparam int            BW       = cnt_width(N_BITS);
    localparam logic [BW-1:0] BIT_LAST = BW'(N_BITS - 1);

    scan_state_t        state;
    scan_state_t        next_state;
    logic               tick;
    logic               div_clr;
    logic [BW-1:0]      bit_cnt;
    logic [BW-1:0]      sample_idx;
    logic [N_BITS-1:0]  shadow;
    logic               first_frame;
    logic               latch_n_q;
    logic               sclk_q;
    logic               load_word;

    // The divider is also cleared in UPDATE so the LOAD phase of a
    // back-to-back frame gets a full tick period.
    assign div_clr = (state == IDLE) || (state == UPDATE);

    dip_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (div_clr),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; scan_en is only looked at between frames.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (scan_en) next_state = LOAD;
            LOAD:     if (tick) next_state = SHIFT_LO;
            SHIFT_LO: if (tick) next_state = SHIFT_HI;
            SHIFT_HI: if (tick) next_state = (bit_cnt == BIT_LAST) ? UPDATE : SHIFT_LO;
            UPDATE:   next_state = scan_en ? LOAD : IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Chain control pins are flops that follow the next state, so they
    // change on the same edge as the FSM and never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_n_q <= 1'b1;
            sclk_q    <= 1'b0;
        end else begin
            latch_n_q <= (next_state != LOAD);
            sclk_q    <= (next_state == SHIFT_HI);
        end
    end

    assign chain.dip_latch_n = latch_n_q;
    assign chain.dip_sclk    = sclk_q;
    assign busy              = (state != IDLE);

    // Bit position within the frame; cleared at the end of LOAD and
    // held at its last value once the final bit is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if ((state == LOAD) && tick) begin
            bit_cnt <= '0;
        end else if ((state == SHIFT_HI) && tick && (bit_cnt != BIT_LAST)) begin
            bit_cnt <= bit_cnt + BW'(1);
        end
    end

    // Map the serial bit position onto the parallel word.
    assign sample_idx = (MSB_FIRST != 0) ? (BIT_LAST - bit_cnt) : bit_cnt;

    // Capture serial data just before the shift clock rises; every
    // shadow bit is rewritten each frame so no clear is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if ((state == SHIFT_LO) && tick) begin
            shadow[sample_idx] <= chain.dip_sin;
        end
    end

`ifdef DIP_DEBOUNCE_EN
    localparam int            MW      = cnt_width(DEB_FRAMES);
    localparam logic [MW-1:0] DEB_MAX = MW'(DEB_FRAMES - 1);

    logic [N_BITS-1:0] last_frame;
    logic [MW-1:0]     match_cnt;
    logic [MW-1:0]     match_next;
    logic              frame_same;

    // Count how many frames in a row matched the previous one and decide
    // whether the stable word may be published.
    always_comb begin
        frame_same = (shadow == last_frame);
        match_next = '0;
        if (frame_same) begin
            match_next = (match_cnt == DEB_MAX) ? match_cnt : match_cnt + MW'(1);
        end
        load_word = first_frame || ((match_next == DEB_MAX) && (shadow != data_out));
    end

    // Debounce history, advanced once per completed frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_frame <= '0;
            match_cnt  <= '0;
        end else if (state == UPDATE) begin
            match_cnt <= match_next;
            if (!frame_same) begin
                last_frame <= shadow;
            end
        end
    end
`else
    // Every frame is published; only a different word counts as a change.
    assign load_word = first_frame || (shadow != data_out);
`endif

    // Publish the frame: valid every frame, data/changed only on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out     <= '0;
            data_valid   <= 1'b0;
            data_changed <= 1'b0;
            first_frame  <= 1'b1;
        end else begin
            data_valid   <= (state == UPDATE);
            data_changed <= (state == UPDATE) && load_word;
            if (state == UPDATE) begin
                if (load_word) begin
                    data_out <= shadow;
                end
                first_frame <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dip_scan_reader.sv
// Self-checking bench for dip_scan_reader.
// Two readers share clock and reset: dut0 is MSB-first, dut1 LSB-first.
// Each has a behavioural 74HC165 chain model fed from sw0 / sw1.
// Build with DIP_DEBOUNCE_EN defined to exercise the debounce variant.
module tb_dip_scan_reader;

`ifdef DIP_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_en0 = 1'b0;
    logic        scan_en1 = 1'b0;
    logic [23:0] sw0 = '0;
    logic [23:0] sw1 = '0;
    logic [23:0] chain0 = '0;
    logic [23:0] chain1 = '0;
    logic        sclk_prev0 = 1'b0;
    logic        sclk_prev1 = 1'b0;

    logic [23:0] data_out0, data_out1;
    logic        data_valid0, data_valid1;
    logic        data_changed0, data_changed1;
    logic        busy0, busy1;

    int checks = 0;
    int passed = 0;

    dip_scan_reader_if bus0 ();
    dip_scan_reader_if bus1 ();

    assign bus0.dip_sin = chain0[23];
    assign bus1.dip_sin = chain1[23];

    dip_scan_reader #(.N_BITS(24), .CLK_DIV(4), .MSB_FIRST(1), .DEB_FRAMES(2)) dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .scan_en      (scan_en0),
        .chain        (bus0.master),
        .data_out     (data_out0),
        .data_valid   (data_valid0),
        .data_changed (data_changed0),
        .busy         (busy0)
    );

    dip_scan_reader #(.N_BITS(24), .CLK_DIV(4), .MSB_FIRST(0), .DEB_FRAMES(2)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .scan_en      (scan_en1),
        .chain        (bus1.master),
        .data_out     (data_out1),
        .data_valid   (data_valid1),
        .data_changed (data_changed1),
        .busy         (busy1)
    );

    always #5 clk = ~clk;

    // Chain models: parallel load while latch is low, shift toward the
    // serial output on each rising shift clock.
    always @(posedge clk) begin
        sclk_prev0 <= bus0.dip_sclk;
        sclk_prev1 <= bus1.dip_sclk;
        if (!bus0.dip_latch_n) chain0 <= sw0;
        else if (bus0.dip_sclk && !sclk_prev0) chain0 <= {chain0[22:0], 1'b0};
        if (!bus1.dip_latch_n) chain1 <= sw1;
        else if (bus1.dip_sclk && !sclk_prev1) chain1 <= {chain1[22:0], 1'b0};
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Clocks until data_valid is seen (0 if the limit expires).
    task automatic wait_valid(input bit which, input int limit, output int cycles);
        cycles = 0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if (which ? data_valid1 : data_valid0) begin
                cycles = i;
                break;
            end
        end
    endtask

    // Wait for n rising shift clocks on the selected chain.
    task automatic wait_sclk_rises(input bit which, input int n, output bit ok);
        int  rises = 0;
        logic prev = 1'b0;
        logic cur;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            cur = which ? bus1.dip_sclk : bus0.dip_sclk;
            if (cur && !prev) rises++;
            prev = cur;
            if (rises == n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        scan_en0 = 1'b1;
        scan_en1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (bus0.dip_latch_n !== 1'b1) $display("[TB] FAIL reset_latch_n: got %b want 1", bus0.dip_latch_n); else passed++;
            checks++; if (bus0.dip_sclk !== 1'b0) $display("[TB] FAIL reset_sclk: got %b want 0", bus0.dip_sclk); else passed++;
            checks++; if (data_out0 !== 24'h0) $display("[TB] FAIL reset_data_out: got %h want 000000", data_out0); else passed++;
            checks++; if (busy0 !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy0); else passed++;
        end
        scan_en0 = 1'b0;
        scan_en1 = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy0 !== 1'b0) $display("[TB] FAIL idle_after_reset_busy: got %b want 0", busy0); else passed++;
    endtask

    task automatic test_first_frame();
        int cyc;
        sw0 = 24'hA5C30F;
        scan_en0 = 1'b1;
        wait_valid(1'b0, 400, cyc);
        checks++; if (cyc !== 198) $display("[TB] FAIL first_latency: got %0d clk want 198", cyc); else passed++;
        checks++; if (data_out0 !== 24'hA5C30F) $display("[TB] FAIL first_data: got %h want a5c30f", data_out0); else passed++;
        checks++; if (data_changed0 !== 1'b1) $display("[TB] FAIL first_changed: got %b want 1", data_changed0); else passed++;
        @(posedge clk); #1;
        checks++; if (data_valid0 !== 1'b0) $display("[TB] FAIL valid_pulse_width: got %b want 0", data_valid0); else passed++;
        checks++; if (data_changed0 !== 1'b0) $display("[TB] FAIL changed_pulse_width: got %b want 0", data_changed0); else passed++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        wait_valid(1'b0, 260, cyc);
        checks++; if (cyc !== 196) $display("[TB] FAIL repeat_period: got %0d clk want 196", cyc); else passed++;
        checks++; if (data_out0 !== 24'hA5C30F) $display("[TB] FAIL repeat_data: got %h want a5c30f", data_out0); else passed++;
        checks++; if (data_changed0 !== 1'b0) $display("[TB] FAIL repeat_changed: got %b want 0", data_changed0); else passed++;
        sw0 = 24'h000001;
        wait_valid(1'b0, 260, cyc);
        checks++; if (cyc !== 197) $display("[TB] FAIL change_period: got %0d clk want 197", cyc); else passed++;
        checks++; if (data_out0 !== (DEB ? 24'hA5C30F : 24'h000001)) $display("[TB] FAIL change_data: got %h want %h", data_out0, DEB ? 24'hA5C30F : 24'h000001); else passed++;
        checks++; if (data_changed0 !== !DEB) $display("[TB] FAIL change_changed: got %b want %b", data_changed0, !DEB); else passed++;
        scan_en0 = 1'b0;
        wait_valid(1'b0, 260, cyc);
        checks++; if (cyc !== 197) $display("[TB] FAIL last_period: got %0d clk want 197", cyc); else passed++;
        checks++; if (data_out0 !== 24'h000001) $display("[TB] FAIL settled_data: got %h want 000001", data_out0); else passed++;
        checks++; if (data_changed0 !== DEB) $display("[TB] FAIL settled_changed: got %b want %b", data_changed0, DEB); else passed++;
        checks++; if (busy0 !== 1'b0) $display("[TB] FAIL stop_busy: got %b want 0", busy0); else passed++;
    endtask

    task automatic test_lsb_first();
        int cyc;
        bit ok;
        bit restarted = 1'b0;
        sw1 = 24'hA5C30F;
        scan_en1 = 1'b1;
        wait_sclk_rises(1'b1, 11, ok);
        checks++; if (ok !== 1'b1) $display("[TB] FAIL lsb_sclk_timeout: got %b want 1", ok); else passed++;
        scan_en1 = 1'b0;
        wait_valid(1'b1, 400, cyc);
        checks++; if (cyc == 0) $display("[TB] FAIL lsb_valid_timeout: got %0d clk want nonzero", cyc); else passed++;
        checks++; if (data_out1 !== 24'hF0C3A5) $display("[TB] FAIL lsb_data: got %h want f0c3a5", data_out1); else passed++;
        checks++; if (data_changed1 !== 1'b1) $display("[TB] FAIL lsb_changed: got %b want 1", data_changed1); else passed++;
        checks++; if (busy1 !== 1'b0) $display("[TB] FAIL lsb_busy: got %b want 0", busy1); else passed++;
        for (int i = 0; i < 250; i++) begin
            @(posedge clk); #1;
            if (data_valid1 || busy1 || !bus1.dip_latch_n) restarted = 1'b1;
        end
        checks++; if (restarted !== 1'b0) $display("[TB] FAIL lsb_stays_idle: got %b want 0", restarted); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int cyc;
        bit ok;
        sw0 = 24'h3C5A96;
        scan_en0 = 1'b1;
        wait_sclk_rises(1'b0, 8, ok);
        checks++; if (ok !== 1'b1) $display("[TB] FAIL mid_sclk_timeout: got %b want 1", ok); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus0.dip_latch_n !== 1'b1) $display("[TB] FAIL mid_latch_n: got %b want 1", bus0.dip_latch_n); else passed++;
        checks++; if (bus0.dip_sclk !== 1'b0) $display("[TB] FAIL mid_sclk: got %b want 0", bus0.dip_sclk); else passed++;
        checks++; if (data_out0 !== 24'h0) $display("[TB] FAIL mid_data_out: got %h want 000000", data_out0); else passed++;
        checks++; if (busy0 !== 1'b0) $display("[TB] FAIL mid_busy: got %b want 0", busy0); else passed++;
        checks++; if (data_valid0 !== 1'b0) $display("[TB] FAIL mid_valid: got %b want 0", data_valid0); else passed++;
        scan_en0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        scan_en0 = 1'b1;
        repeat (2) @(posedge clk);
        #1 scan_en0 = 1'b0;
        wait_valid(1'b0, 400, cyc);
        checks++; if (cyc !== 196) $display("[TB] FAIL clean_latency: got %0d clk want 196", cyc); else passed++;
        checks++; if (data_out0 !== 24'h3C5A96) $display("[TB] FAIL clean_data: got %h want 3c5a96", data_out0); else passed++;
        checks++; if (data_changed0 !== 1'b1) $display("[TB] FAIL clean_changed: got %b want 1", data_changed0); else passed++;
    endtask

    task automatic test_debounce();
        logic [23:0] frames  [5] = '{24'h000003, 24'h00000F, 24'h00001F, 24'h00000F, 24'h00000F};
        logic [23:0] exp_out [5];
        logic        exp_chg [5];
        int cyc;
        if (DEB) begin
            exp_out = '{24'h000003, 24'h000003, 24'h000003, 24'h000003, 24'h00000F};
            exp_chg = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        end else begin
            exp_out = '{24'h000003, 24'h00000F, 24'h00001F, 24'h00000F, 24'h00000F};
            exp_chg = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        end
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        sw0 = frames[0];
        scan_en0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_valid(1'b0, 260, cyc);
            checks++; if (cyc == 0) $display("[TB] FAIL deb_timeout[%0d]: got %0d clk want nonzero", i, cyc); else passed++;
            checks++; if (data_out0 !== exp_out[i]) $display("[TB] FAIL deb_data[%0d]: got %h want %h", i, data_out0, exp_out[i]); else passed++;
            checks++; if (data_changed0 !== exp_chg[i]) $display("[TB] FAIL deb_changed[%0d]: got %b want %b", i, data_changed0, exp_chg[i]); else passed++;
            if (i < 4) sw0 = frames[i + 1];
            if (i == 3) scan_en0 = 1'b0;
        end
        checks++; if (busy0 !== 1'b0) $display("[TB] FAIL deb_idle: got %b want 0", busy0); else passed++;
    endtask

    initial begin
        $display("[TB] dip_scan_reader bench start (debounce build = %0d)", DEB);
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_lsb_first();
        test_reset_mid_frame();
        test_debounce();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dip_scan_reader.md
Name: dip_scan_reader

Overview:
Parametrised serial reader for a chain of parallel-load shift registers (74HC165-style) behind the board DIP switches. It generates its own divided serial clock and an active-low load strobe, then shifts in N_BITS per frame. It publishes a registered parallel word with valid/changed strobes, scanning continuously while enabled. It replaces the fixed 24-bit reader and feeds the switch word to the control/register-file logic.

Parameters:
N_BITS, 24, switch bits per frame (>=1).
CLK_DIV, 4, clk cycles per scan tick (>=2).
MSB_FIRST, 1, 1: first serial bit lands in data_out[N_BITS-1]; 0: first bit lands in data_out[0].
DEB_FRAMES, 2, identical consecutive frames needed before data_out updates (used only with DIP_DEBOUNCE_EN; >=2).

Ports:
clk  input  1  system clock; all logic on posedge clk.
rst_n  input  1  asynchronous active-low reset.
scan_en  input  1  level; 1 = scan continuously, 0 = stop after the current frame.
dip_sin  input  1  serial data from the last register in the chain.
dip_sclk  output  1  serial shift clock to the chain.
dip_latch_n  output  1  parallel-load strobe, active low.
data_out  output  N_BITS  last accepted switch word.
data_valid  output  1  one-clk pulse per completed frame.
data_changed  output  1  one-clk pulse when data_out takes a new value.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, dip_latch_n=1, dip_sclk=0, data_out=0, data_valid=0, data_changed=0, busy=0, divider=0, bit counter=0, first_frame flag=1.
- Tick: divider counts 0..CLK_DIV-1 and asserts tick for one clk at CLK_DIV-1. The divider runs only outside IDLE and clears on leaving IDLE.
- IDLE: outputs idle. When scan_en=1, go to LOAD on the next clk.
- LOAD: dip_latch_n=0 for exactly one tick period. On the tick, set dip_latch_n=1, clear the bit counter and go to SHIFT_LO.
- SHIFT_LO: dip_sclk=0. On the tick, sample dip_sin into the shadow register at the current bit position, raise dip_sclk and go to SHIFT_HI.
- SHIFT_HI: dip_sclk=1. On the tick, lower dip_sclk. If the bit counter equals N_BITS-1, go to UPDATE; else increment the counter and go to SHIFT_LO.
- UPDATE (one clk):
  - Pulse data_valid.
  - Apply the update rule below.
  - Go to LOAD if scan_en=1, else IDLE.
- Update rule without debounce: data_out <= shadow. data_changed=1 if shadow != data_out or first_frame=1. Then clear first_frame.
- Frame length: (1 + 2*N_BITS)*CLK_DIV + 1 clk. Defaults give 197 clk.
- scan_en is sampled only in IDLE and UPDATE. Deasserting it mid-frame never truncates the frame.
- Shadow register is N_BITS wide, with no wrap. The bit counter is clog2(N_BITS) wide, saturating at N_BITS-1.
- Bits already shifted are not cleared between frames. Every shadow bit is overwritten each frame.
- Async reset mid-frame aborts immediately with no partial data_out update. dip_latch_n returns high combinationally from the reset flop value.

Optional Feature:
DIP_DEBOUNCE_EN.
- Defined: hold last_frame and a match counter (0..DEB_FRAMES-1).
  - At UPDATE, if shadow == last_frame, increment the counter (saturating); else reset it to 0 and set last_frame <= shadow.
  - data_out loads only when the counter reaches DEB_FRAMES-1 and shadow != data_out, or on first_frame. data_changed pulses only then.
  - data_valid still pulses every frame.
  - Reset clears last_frame and the counter.
- Undefined: the debounce logic is absent and every frame updates data_out per the base rule.

Decomposition:
- Package dip_scan_pkg:
  - state enum {IDLE, LOAD, SHIFT_LO, SHIFT_HI, UPDATE}
  - function for the clog2 widths of the divider and bit counter
- Sub-module dip_tick_gen: parametrised CLK_DIV divider with clr input and tick output.

Test Plan:
- Reset: rst_n=0 for 3 clk, scan_en=1 → dip_latch_n=1, dip_sclk=0, data_out=0, busy=0 throughout.
- N_BITS=24, CLK_DIV=4, MSB_FIRST=1, chain model loaded with 0xA5C30F → data_out=0xA5C30F, data_valid at clk 197 after leaving IDLE, data_changed=1 (first frame).
- Second identical frame → data_valid=1, data_changed=0. Then switch to 0x000001 → data_changed=1 and data_out=0x000001 one frame later.
- MSB_FIRST=0 with the same chain data → data_out bit-reversed (0xF0C3A5). scan_en dropped at bit 10 → frame completes, returns to IDLE, busy=0.
- DIP_DEBOUNCE_EN, DEB_FRAMES=2: frames 0x0F, 0x1F (glitch), 0x0F, 0x0F → data_out changes only after the 4th frame. A glitch frame alone never reaches data_out.
- Assert rst_n=0 during SHIFT_HI bit 7 → immediate idle outputs, data_out=0. After release, a full clean frame is read correctly.
